// File: rtl/motor602_dt_pkg.sv
// Shared definitions for the motor602 dead-time inserter: phase FSM state
// encoding, the default dead time and the phase index constants.
package motor602_dt_pkg;

    typedef enum logic [1:0] {
        DT_OFF = 2'b00,
        DT_HON = 2'b01,
        DT_LON = 2'b10
    } dtState_t;

    localparam int DEAD_CYC_DEF = 20;
    localparam int NUM_PH       = 3;
    localparam int SHOOT_CNT_W  = 8;

    localparam int PH_A = 0;
    localparam int PH_B = 1;
    localparam int PH_C = 2;

    // Number of phases raising a new shoot-through event in one cycle.
    function automatic logic [1:0] countOnes3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/motor602_dt_phase.sv
// One phase of the dead-time inserter: OFF/HON/LON state machine, the
// dead-time counter that gates every on-entry, and the sticky fault flag.
module motor602_dt_phase
    import motor602_dt_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int CNT_W    = 8
) (
    input  logic clkI,
    input  logic rstI,
    input  logic enableI,
    input  logic clearI,
    input  logic hReqI,
    input  logic lReqI,
    output logic hGateO,
    output logic lGateO,
    output logic faultO,
    output logic dtBusyO
);

    localparam logic [CNT_W-1:0] DT_LOAD = CNT_W'(DEAD_CYC - 1);

    dtState_t         state;
    logic [CNT_W-1:0] dtCnt;
    logic             fault;

    logic shoot;
    logic dtDone;
    logic hOnOk;
    logic lOnOk;
    logic hOffReq;
    logic lOffReq;

    assign shoot   = hReqI & lReqI;
    assign dtDone  = (dtCnt == '0);
    assign hOnOk   = hReqI & ~lReqI & dtDone & enableI & ~fault;
    assign lOnOk   = lReqI & ~hReqI & dtDone & enableI & ~fault;
    assign hOffReq = ~hReqI | lReqI | ~enableI | shoot;
    assign lOffReq = ~lReqI | hReqI | ~enableI | shoot;

    // A reversal can only go through OFF, so every turn-on sees the full
    // dead time reloaded on the edge that left the previous on-state.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            state <= DT_OFF;
            dtCnt <= DT_LOAD;
            fault <= 1'b0;
        end else begin
            if (shoot) begin
                fault <= 1'b1;
            end else if (clearI) begin
                fault <= 1'b0;
            end

            case (state)
                DT_OFF: begin
                    if (hOnOk) begin
                        state <= DT_HON;
                    end else if (lOnOk) begin
                        state <= DT_LON;
                    end else if (!dtDone) begin
                        dtCnt <= dtCnt - CNT_W'(1);
                    end
                end
                DT_HON: begin
                    if (hOffReq) begin
                        state <= DT_OFF;
                        dtCnt <= DT_LOAD;
                    end
                end
                DT_LON: begin
                    if (lOffReq) begin
                        state <= DT_OFF;
                        dtCnt <= DT_LOAD;
                    end
                end
                default: begin
                    state <= DT_OFF;
                    dtCnt <= DT_LOAD;
                end
            endcase
        end
    end

    assign hGateO  = (state == DT_HON);
    assign lGateO  = (state == DT_LON);
    assign faultO  = fault;
    assign dtBusyO = (state == DT_OFF) & ~dtDone;

endmodule

// File: rtl/motor602_deadtime.sv
// Three-phase dead-time inserter and shoot-through guard with a saturating
// count of shoot-through events across all phases.
module motor602_deadtime
    import motor602_dt_pkg::*;
#(
    parameter int DEAD_CYC = DEAD_CYC_DEF,
    parameter int CNT_W    = 8
) (
    input  logic                   clkI,
    input  logic                   rstI,
    input  logic                   enableI,
    input  logic                   clearI,
    input  logic [NUM_PH-1:0]      hReqI,
    input  logic [NUM_PH-1:0]      lReqI,
    output logic [NUM_PH-1:0]      hGateO,
    output logic [NUM_PH-1:0]      lGateO,
    output logic [NUM_PH-1:0]      faultO,
    output logic [NUM_PH-1:0]      dtBusyO,
    output logic [SHOOT_CNT_W-1:0] shootCntO
);

    localparam logic [SHOOT_CNT_W:0] CNT_MAX = {1'b0, {SHOOT_CNT_W{1'b1}}};

    logic [NUM_PH-1:0]      shoot;
    logic [NUM_PH-1:0]      shootPrev;
    logic [NUM_PH-1:0]      shootRise;
    logic [SHOOT_CNT_W:0]   cntSum;
    logic [SHOOT_CNT_W-1:0] shootCnt;

    assign shoot     = hReqI & lReqI;
    assign shootRise = shoot & ~shootPrev;
    assign cntSum    = {1'b0, shootCnt} + (SHOOT_CNT_W + 1)'(countOnes3(shootRise));

    motor602_dt_phase #(
        .DEAD_CYC (DEAD_CYC),
        .CNT_W    (CNT_W)
    ) phaseA (
        .clkI    (clkI),
        .rstI    (rstI),
        .enableI (enableI),
        .clearI  (clearI),
        .hReqI   (hReqI[PH_A]),
        .lReqI   (lReqI[PH_A]),
        .hGateO  (hGateO[PH_A]),
        .lGateO  (lGateO[PH_A]),
        .faultO  (faultO[PH_A]),
        .dtBusyO (dtBusyO[PH_A])
    );

    motor602_dt_phase #(
        .DEAD_CYC (DEAD_CYC),
        .CNT_W    (CNT_W)
    ) phaseB (
        .clkI    (clkI),
        .rstI    (rstI),
        .enableI (enableI),
        .clearI  (clearI),
        .hReqI   (hReqI[PH_B]),
        .lReqI   (lReqI[PH_B]),
        .hGateO  (hGateO[PH_B]),
        .lGateO  (lGateO[PH_B]),
        .faultO  (faultO[PH_B]),
        .dtBusyO (dtBusyO[PH_B])
    );

    motor602_dt_phase #(
        .DEAD_CYC (DEAD_CYC),
        .CNT_W    (CNT_W)
    ) phaseC (
        .clkI    (clkI),
        .rstI    (rstI),
        .enableI (enableI),
        .clearI  (clearI),
        .hReqI   (hReqI[PH_C]),
        .lReqI   (lReqI[PH_C]),
        .hGateO  (hGateO[PH_C]),
        .lGateO  (lGateO[PH_C]),
        .faultO  (faultO[PH_C]),
        .dtBusyO (dtBusyO[PH_C])
    );

    // Only new shoot-through events count, one per phase, so a held
    // overlap registers once and the total sticks at full scale.
    always_ff @(posedge clkI) begin
        if (rstI) begin
            shootPrev <= '0;
            shootCnt  <= '0;
        end else begin
            shootPrev <= shoot;
            if (cntSum > CNT_MAX) begin
                shootCnt <= CNT_MAX[SHOOT_CNT_W-1:0];
            end else begin
                shootCnt <= cntSum[SHOOT_CNT_W-1:0];
            end
        end
    end

    assign shootCntO = shootCnt;

endmodule

// File: tb/tb_motor602_deadtime.sv
// Randomized and directed bench for motor602_deadtime, checked every cycle
// against a behavioural model that counts elapsed all-off cycles per phase.
`timescale 1ns/1ps
module tb_motor602_deadtime;

    localparam int DEAD = 20;

    logic       clkI = 1'b0;
    logic       rstI;
    logic       enableI;
    logic       clearI;
    logic [2:0] hReqI;
    logic [2:0] lReqI;
    logic [2:0] hGateO;
    logic [2:0] lGateO;
    logic [2:0] faultO;
    logic [2:0] dtBusyO;
    logic [7:0] shootCntO;

    int checks = 0;
    int errors = 0;

    // Model: side 0 = off, 1 = high on, 2 = low on; offCyc = cycles spent all-off.
    int mSide[3];
    int mOffCyc[3];
    bit mFault[3];
    bit mPrevShoot[3];
    int mCnt;

    motor602_deadtime #(
        .DEAD_CYC (DEAD),
        .CNT_W    (8)
    ) dut (
        .clkI      (clkI),
        .rstI      (rstI),
        .enableI   (enableI),
        .clearI    (clearI),
        .hReqI     (hReqI),
        .lReqI     (lReqI),
        .hGateO    (hGateO),
        .lGateO    (lGateO),
        .faultO    (faultO),
        .dtBusyO   (dtBusyO),
        .shootCntO (shootCntO)
    );

    always #50 clkI = ~clkI;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void modelStep(input logic [2:0] h, input logic [2:0] l,
                                      input logic en, input logic clr, input logic rst);
        int nCnt;
        nCnt = mCnt;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mSide[i]      = 0;
                mOffCyc[i]    = 1;
                mFault[i]     = 1'b0;
                mPrevShoot[i] = 1'b0;
            end else begin
                bit shoot;
                shoot = h[i] && l[i];
                if (shoot && !mPrevShoot[i]) nCnt++;
                mPrevShoot[i] = shoot;
                case (mSide[i])
                    0: begin
                        if (en && !mFault[i] && mOffCyc[i] >= DEAD && h[i] != l[i])
                            mSide[i] = h[i] ? 1 : 2;
                        else if (mOffCyc[i] < 1000)
                            mOffCyc[i]++;
                    end
                    1: if (!h[i] || l[i] || !en) begin mSide[i] = 0; mOffCyc[i] = 1; end
                    default: if (!l[i] || h[i] || !en) begin mSide[i] = 0; mOffCyc[i] = 1; end
                endcase
                if (shoot) mFault[i] = 1'b1;
                else if (clr) mFault[i] = 1'b0;
            end
        end
        mCnt = rst ? 0 : (nCnt > 255 ? 255 : nCnt);
    endfunction

    task automatic checkModel();
        logic [2:0] eH, eL, eF, eB;
        for (int i = 0; i < 3; i++) begin
            eH[i] = (mSide[i] == 1);
            eL[i] = (mSide[i] == 2);
            eF[i] = mFault[i];
            eB[i] = (mSide[i] == 0) && (mOffCyc[i] < DEAD);
        end
        checkOutput("hGate", {29'd0, hGateO}, {29'd0, eH});
        checkOutput("lGate", {29'd0, lGateO}, {29'd0, eL});
        checkOutput("fault", {29'd0, faultO}, {29'd0, eF});
        checkOutput("dtBusy", {29'd0, dtBusyO}, {29'd0, eB});
        checkOutput("shootCnt", {24'd0, shootCntO}, mCnt);
        checkOutput("overlap", {29'd0, hGateO & lGateO}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [2:0] h, input logic [2:0] l,
                                 input logic en, input logic clr, input logic rst);
        hReqI   = h;
        lReqI   = l;
        enableI = en;
        clearI  = clr;
        rstI    = rst;
        @(posedge clkI);
        modelStep(h, l, en, clr, rst);
        #1;
        checkModel();
    endtask

    initial begin
        int busyFall, riseAt, lows;

        for (int k = 0; k < 3; k++) applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        checkOutput("rstBusy", {29'd0, dtBusyO}, 32'd7);

        // Reset release with phase a requesting high.
        busyFall = -1;
        riseAt   = -1;
        for (int k = 1; k <= 40; k++) begin
            applyStimulus(3'b001, 3'b000, 1'b1, 1'b0, 1'b0);
            if (busyFall < 0 && !dtBusyO[0]) busyFall = k;
            if (riseAt < 0 && hGateO[0]) riseAt = k;
        end
        checkOutput("releaseBusyFall", busyFall, 19);
        checkOutput("releaseRise", riseAt, 20);

        // All phases high, then a one-cycle enable drop.
        for (int k = 0; k < 25; k++) applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, 1'b0);
        lows = 1;
        for (int k = 0; k < 60 && hGateO != 3'b111; k++) begin
            applyStimulus(3'b111, 3'b000, 1'b1, 1'b0, 1'b0);
            if (hGateO != 3'b111) lows++;
        end
        checkOutput("enableReentryLow", lows, 20);

        // Reversal on phase b.
        lows = 0;
        for (int k = 0; k < 60 && !lGateO[1]; k++) begin
            applyStimulus(3'b101, 3'b010, 1'b1, 1'b0, 1'b0);
            if (!lGateO[1] && !hGateO[1]) lows++;
        end
        checkOutput("reversalGap", lows, 20);

        // Phase c to low side, then a three-cycle shoot-through.
        for (int k = 0; k < 25; k++) applyStimulus(3'b001, 3'b110, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(3'b101, 3'b110, 1'b1, 1'b0, 1'b0);
        checkOutput("shootCntOnce", {24'd0, shootCntO}, 32'd1);
        for (int k = 0; k < 30; k++) applyStimulus(3'b001, 3'b110, 1'b1, 1'b0, 1'b0);
        checkOutput("faultBlocksOn", {31'd0, lGateO[2]}, 32'd0);
        applyStimulus(3'b001, 3'b110, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(3'b001, 3'b110, 1'b1, 1'b0, 1'b0);

        // Clear coinciding with a shoot-through.
        applyStimulus(3'b101, 3'b110, 1'b1, 1'b1, 1'b0);
        checkOutput("clearVsShoot", {31'd0, faultO[2]}, 32'd1);

        // Randomized segments of held request patterns.
        for (int s = 0; s < 120; s++) begin
            logic [2:0] h, l;
            int len;
            bit doRst;
            for (int i = 0; i < 3; i++) begin
                int r;
                r = $urandom_range(0, 15);
                h[i] = (r <= 6) || (r == 15);
                l[i] = (r >= 7 && r <= 12) || (r == 15);
            end
            len   = $urandom_range(1, 45);
            doRst = ($urandom_range(0, 59) == 0);
            for (int c = 0; c < len; c++)
                applyStimulus(h, l, $urandom_range(0, 79) != 0,
                              $urandom_range(0, 24) == 0, doRst && c == 0);
        end

        // Saturation of the shoot-through count, then a mid-test reset.
        applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(3'b001, 3'b001, 1'b1, 1'b0, 1'b0);
            applyStimulus(3'b000, 3'b000, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("saturate", {24'd0, shootCntO}, 32'd255);
        for (int k = 0; k < 25; k++) applyStimulus(3'b110, 3'b000, 1'b1, 1'b0, 1'b0);
        applyStimulus(3'b110, 3'b000, 1'b1, 1'b0, 1'b1);
        checkOutput("rstCnt", {24'd0, shootCntO}, 32'd0);
        checkOutput("rstGates", {26'd0, hGateO, lGateO}, 32'd0);
        for (int k = 0; k < 25; k++) applyStimulus(3'b110, 3'b000, 1'b1, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/motor602_deadtime.md
# motor602_deadtime

Per-phase dead-time inserter and shoot-through guard placed directly downstream of the motor602 commutation core. It takes the raw high/low gate requests for phases a, b and c and produces gate commands in which the high and low switch of a phase are never on together. Each on-transition is preceded by a programmable all-off interval. The block's outputs feed the output register stage, which applies the low-side polarity inversion, so this block works purely in positive logic.

## Interface
Parameters:
- DEAD_CYC, 20, all-off cycles enforced before any switch turns on (2 µs at 10 MHz); legal range 2..255
- CNT_W, 8, width of the dead-time counter

Ports:
- clkI  in  1  system clock, 10 MHz
- rstI  in  1  reset, synchronous, active-high
- enableI  in  1  global gate enable; low forces all phases off
- clearI  in  1  one-cycle pulse that clears all sticky faults
- hReqI  in  3  high-side requests; bit 0 = a, 1 = b, 2 = c
- lReqI  in  3  low-side requests, same bit order
- hGateO  out  3  high-side gate commands, positive logic
- lGateO  out  3  low-side gate commands, positive logic
- faultO  out  3  sticky shoot-through fault flag per phase
- dtBusyO  out  3  phase is off and its dead-time counter is non-zero
- shootCntO  out  8  saturating count of shoot-through request events, all phases

## Operation
- There are three identical phase FSMs. Each has the states OFF, HON and LON.
- Gate outputs are decoded from registered state: hGateO[i] = (state==HON), lGateO[i] = (state==LON).
- Per-phase counter dtCnt:
  - Loaded with DEAD_CYC-1 on every edge that enters OFF from HON or LON.
  - Decrements once per cycle while in OFF and non-zero.
  - Holds at 0.
- OFF → HON when hReq & !lReq & dtCnt==0 & enableI & !fault.
- OFF → LON uses the same condition with the roles of hReq and lReq swapped.
- HON → OFF when !hReq | lReq | !enableI | fault-set. LON → OFF mirrors this.
- There is never a direct HON↔LON transition. A reversal always passes through OFF with the full dead time.
- Shoot-through is hReq & lReq on a phase in the same cycle.
  - It forces that phase to OFF.
  - It sets faultO[i].
  - On its rising edge (not asserted the previous cycle) it increments shootCntO by one, saturating at 255.
- Simultaneous rising events on several phases in one cycle add 1 per phase. The sum still saturates at 255.
- Fault blocks all on-entries of that phase until clearI.
- If clearI and a shoot-through condition occur in the same cycle, set wins.
- clearI does not reset shootCntO; only rstI does.
- enableI low: every phase goes to OFF next edge. Counters keep running, so dead time still applies on re-enable.

## Timing
- Reset values:
  - state = OFF, dtCnt = DEAD_CYC-1
  - hGateO = lGateO = 0, faultO = 0, shootCntO = 0
  - dtBusyO = 3'b111
- After reset release, the first turn-on occurs no earlier than DEAD_CYC cycles later.
- Turn-on latency: 1 cycle from request sampled (with dtCnt==0) to gate high.
- Turn-off latency: 1 cycle from request drop, enable drop, or shoot-through to gate low.
- Minimum all-off interval between opposite switches of a phase: exactly DEAD_CYC cycles.
- A request that drops during dead time is ignored; no turn-on happens.
- A re-request of the same side during dead time still waits the full count.
- rstI mid-operation: all gates are low on the next edge and the counters reload.
- Faults and counts update on the same edge that forces OFF.

## Structure
- Package motor602_dt_pkg holds:
  - the state encoding (OFF/HON/LON, 2 bits)
  - the DEAD_CYC default
  - the phase index constants A/B/C
- Sub-module motor602_dt_phase contains one FSM, its dead-time counter and its fault flag. It is instantiated three times.
- The top level holds the shoot-through edge registers and the saturating shootCntO adder.

## Test plan
All scenarios use DEAD_CYC=20.
- **Reset release:** hold hReqI=3'b001 from reset release. Expect hGateO[0] to rise on cycle 20 after release and dtBusyO[0] to fall on cycle 19.
- **Reversal on phase b:** while HON, switch to lReqI[1]=1 and hReqI[1]=0. Expect hGateO[1] low 1 cycle later, exactly 20 cycles with both low, then lGateO[1] high.
- **Shoot-through on phase c:** while LON, assert hReqI[2]=lReqI[2]=1 for 3 cycles. Expect:
  - lGateO[2] low next cycle.
  - faultO[2]=1.
  - shootCntO=1, not 3.
  - No turn-on until clearI, then turn-on after the remaining dead time.
- **clearI with shoot-through:** pulse clearI in the same cycle as a shoot-through. Expect faultO to stay 1.
- **enableI drop:** drop enableI for 1 cycle with all three phases HON. Expect all gates low next cycle and re-entry only after 20 off cycles.
- **Saturation:** generate 300 separated shoot-through pulses on phase a. Expect shootCntO to stop at 255. A mid-test rstI returns it to 0 with all gates low.
